alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 16 +
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arb_rr.sv | 18 +
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and widths for the two-port ALU arbiter.
//   state_e : arbiter FSM states (IDLE, BUSY, DONE)
//   DATA_W  : operand/result width, OP_W : opcode width,
//   CNT_W   : completed-operation counter width, LAT_W : latency counter width
package alu_arb_pkg;
    localparam int DATA_W = 3;
    localparam int OP_W   = 2;
    localparam int CNT_W  = 8;
    localparam int LAT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the requester, shared-ALU and status signals of
// alu_arbiter.
//   slave  modport : the arbiter's view (requests in, grants/results out)
//   master modport : the environment's view (requesters + shared ALU)
// Optional ErrSticky/ErrClr exist only when ALU_ARB_STICKY_ERR_EN is defined.
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic              Req0, Req1;
    logic [DATA_W-1:0] PortA0, PortA1, PortB0, PortB1;
    logic [OP_W-1:0]   Opcode0, Opcode1;
    logic              Gnt0, Gnt1, Done0, Done1;
    logic [DATA_W-1:0] Result;
    logic              Error;
    logic [DATA_W-1:0] AluA, AluB;
    logic [OP_W-1:0]   AluOp;
    logic [DATA_W-1:0] AluResult;
    logic              AluError;
    logic [CNT_W-1:0]  OpCount;
`ifdef ALU_ARB_STICKY_ERR_EN
    logic              ErrSticky, ErrClr;
`endif

    modport slave (
`ifdef ALU_ARB_STICKY_ERR_EN
        input  ErrClr, output ErrSticky,
`endif
        input  Req0, Req1, PortA0, PortA1, PortB0, PortB1, Opcode0, Opcode1,
        input  AluResult, AluError,
        output Gnt0, Gnt1, Done0, Done1, Result, Error,
        output AluA, AluB, AluOp, OpCount
    );

    modport master (
`ifdef ALU_ARB_STICKY_ERR_EN
        output ErrClr, input ErrSticky,
`endif
        output Req0, Req1, PortA0, PortA1, PortB0, PortB1, Opcode0, Opcode1,
        output AluResult, AluError,
        input  Gnt0, Gnt1, Done0, Done1, Result, Error,
        input  AluA, AluB, AluOp, OpCount
    );
endinterface

// File: rtl/alu_arb_rr.sv
// alu_arb_rr: two-way round-robin pick.
//   req0_i, req1_i : requests
//   last_i         : port served last (0/1)
//   winner_o       : selected port (0/1), meaningful when valid_o
//   valid_o        : at least one request present
module alu_arb_rr (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic winner_o,
    output logic valid_o
);
    always_comb begin
        valid_o  = req0_i | req1_i;
        // On contention favour the port not served last; otherwise take whoever asks.
        winner_o = (req0_i && req1_i) ? ~last_i : req1_i;
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_arbiter_if.slave (requests, operands, grants, done,
//                result/error, registered ALU operands, op counter)
// Parameter ALU_LAT (0..7): ALU cycles from operand presentation to result.
// Optional sticky-error flag enabled by defining ALU_ARB_STICKY_ERR_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    state_e            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              winner, valid;

    alu_arb_rr u_rr (
        .req0_i  (bus.Req0),
        .req1_i  (bus.Req1),
        .last_i  (last_q),
        .winner_o(winner),
        .valid_o (valid)
    );

`ifdef ALU_ARB_STICKY_ERR_EN
    logic sticky_q, sticky_d;
`endif

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        last_d   = last_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        res_d    = res_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
`ifdef ALU_ARB_STICKY_ERR_EN
        sticky_d = bus.ErrClr ? 1'b0 : sticky_q;
`endif
        case (state_q)
            IDLE: if (valid) begin
                state_d  = BUSY;
                lat_d    = LAT_W'(ALU_LAT);
                last_d   = winner;
                alu_a_d  = winner ? bus.PortA1  : bus.PortA0;
                alu_b_d  = winner ? bus.PortB1  : bus.PortB0;
                alu_op_d = winner ? bus.Opcode1 : bus.Opcode0;
                gnt0_d   = ~winner;
                gnt1_d   = winner;
            end
            BUSY: begin
                // BUSY lasts ALU_LAT+1 cycles; capture on the last one.
                if (lat_q == '0) begin
                    state_d = DONE;
                    res_d   = bus.AluResult;
                    err_d   = bus.AluError;
                    done0_d = ~last_q;
                    done1_d = last_q;
`ifdef ALU_ARB_STICKY_ERR_EN
                    if (bus.AluError) sticky_d = 1'b1;
`endif
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            last_q   <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            last_q   <= last_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            res_q    <= res_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef ALU_ARB_STICKY_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end
    assign bus.ErrSticky = sticky_q;
`endif

    assign bus.Gnt0    = gnt0_q;
    assign bus.Gnt1    = gnt1_q;
    assign bus.Done0   = done0_q;
    assign bus.Done1   = done1_q;
    assign bus.Result  = res_q;
    assign bus.Error   = err_q;
    assign bus.AluA    = alu_a_q;
    assign bus.AluB    = alu_b_q;
    assign bus.AluOp   = alu_op_q;
    assign bus.OpCount = cnt_q;
endmodule
